wide_adder_seq: RTL and testbench
=================================

# wide_adder_seq

Multi-cycle, multi-precision add/subtract sequencer that drives a single `adder_32_bit` instance one 32-bit limb per cycle, chaining carry-out into the next limb's carry-in. It lets the MIPS datapath perform wide (default 128-bit) arithmetic without replicating adders. It sits beside the ALU as a start/done coprocessor.

## Interface
- `WORDS`, default 4: number of 32-bit limbs; operand width is `32*WORDS`; legal range 1..16.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a new operation; sampled only in IDLE.
- `op_sub`  in  1  0 = add, 1 = subtract (a − b); sampled with `start`.
- `cin`  in  1  carry-in for add; ignored for subtract.
- `a_in`  in  32*WORDS  operand A; sampled with `start`.
- `b_in`  in  32*WORDS  operand B; sampled with `start`.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse: `sum`, `cout` and `overflow` are final.
- `sum`  out  32*WORDS  registered result; held from `done` until the next accepted `start`.
- `cout`  out  1  final carry out of the top limb; for subtract, 1 = no borrow.
- `overflow`  out  1  two's-complement signed overflow of the full-width result.

## Operation
- States: IDLE, RUN.
- IDLE + `start`:
  - latch `a_reg = a_in`;
  - latch `b_reg = op_sub ? ~b_in : b_in`;
  - set `carry = op_sub ? 1 : cin`;
  - set `idx = 0`, clear `sum`, `cout` and `overflow`;
  - go to RUN.
- IDLE without `start`: hold all registers.
- RUN, each cycle:
  - the adder sees limb `idx` of `a_reg` and `b_reg`, plus `carry`;
  - write the adder's sum into limb `idx` of `sum`;
  - `carry <= adder cout`, `idx <= idx + 1`.
- RUN with `idx == WORDS-1`:
  - `cout <= adder cout`;
  - `overflow <= (a_msb == b_eff_msb) && (sum_msb != a_msb)`, using the top-limb bit 31 values this cycle;
  - `done <= 1`, go to IDLE.
- `start` while in RUN is ignored; it is neither queued nor does it corrupt the operation in flight.
- `done` is asserted in the first IDLE cycle. A `start` in that same cycle is accepted, giving back-to-back operation with no idle gap.
- During RUN, `sum` limbs fill in progressively. `sum` is defined only from `done` onward.
- Arithmetic is modulo 2^(32*WORDS). Subtract is a + ~b + 1.

## Timing
- Reset values:
  - state = IDLE, `idx` = 0, `carry` = 0;
  - `busy` = 0, `done` = 0, `sum` = 0, `cout` = 0, `overflow` = 0.
- Latency: `start` sampled at edge 0; `busy` is high for edges 1..WORDS; `done` is high for the cycle after edge WORDS. WORDS=4 gives done 4 cycles after the accept edge; WORDS=1 gives 1 cycle.
- Throughput: one operation per WORDS cycles with back-to-back `start`.
- `rst` mid-RUN: abort immediately to reset values; no `done` for the aborted operation.
- `rst` and `start` in the same cycle: `rst` wins.

## Structure
- Shared package `adder_pkg`:
  - `LIMB_W = 32`;
  - state encoding `ST_IDLE = 1'b0`, `ST_RUN = 1'b1`;
  - `IDX_W = clog2(WORDS)`, minimum 1.
- One sub-module: the existing `adder_32_bit(a, b, cin, sum, cout)`, instantiated once. All limb muxing and carry chaining live in `wide_adder_seq`.

## Test plan
- Add 5 + 9, `cin`=0, WORDS=4 -> `sum`=14, `cout`=0, `overflow`=0; `done` exactly 4 cycles after accept.
- Add `a`=0x0000_0000_0000_0000_0000_0000_FFFF_FFFF, `b`=1 -> `sum`=0x0000_0000_0000_0000_0000_0001_0000_0000 (carry crosses limb 0→1).
- Add all-ones + 0 with `cin`=1 -> `sum`=0, `cout`=1, `overflow`=0.
- Subtract 128 − 64 -> `sum`=64, `cout`=1. Then 0 − 1 -> `sum`=all-ones, `cout`=0, `overflow`=0.
- Add `a`=0x7FFF…FFFF, `b`=1 -> `sum`=0x8000…0000, `overflow`=1, `cout`=0.
- Control and boundary cases:
  - `start` pulsed mid-RUN -> ignored, original result intact;
  - new `start` on the `done` cycle -> accepted, second `done` 4 cycles later;
  - `rst` in second RUN cycle -> all outputs 0, no `done`;
  - repeat the 5 + 9 case with WORDS=1 -> `done` 1 cycle after accept.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared constants for the wide add/subtract sequencer.
// Pure declarations; no logic, no latency.
// No flow control of its own.
package adder_pkg;

    localparam int LIMB_W = 32;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Width of the limb index; a single-limb build still needs a 1-bit register.
    function automatic int idx_width(input int words);
        return (words <= 1) ? 1 : $clog2(words);
    endfunction

endpackage

// File: rtl/adder_32_bit.sv
// Single 32-bit ripple adder with carry in/out, the one arithmetic unit shared by the sequencer.
// Purely combinational, zero cycles.
// No flow control; the caller presents operands every cycle it needs a result.
module adder_32_bit
    import adder_pkg::*;
(
    input  logic [LIMB_W-1:0] a,
    input  logic [LIMB_W-1:0] b,
    input  logic              cin,
    output logic [LIMB_W-1:0] sum,
    output logic              cout
);

    // Widen by one bit so the carry out falls out of the same addition.
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{LIMB_W{1'b0}}, cin};

endmodule

// File: rtl/wide_adder_seq.sv
// Multi-precision add/subtract: one 32-bit limb per cycle through a single shared adder.
// Latency WORDS cycles from the accepting edge to done; one operation per WORDS cycles.
// start is only honoured in IDLE (including the done cycle); a start during RUN is dropped.
module wide_adder_seq
    import adder_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      op_sub,
    input  logic                      cin,
    input  logic [LIMB_W*WORDS-1:0]   a_in,
    input  logic [LIMB_W*WORDS-1:0]   b_in,
    output logic                      busy,
    output logic                      done,
    output logic [LIMB_W*WORDS-1:0]   sum,
    output logic                      cout,
    output logic                      overflow
);

    localparam int W     = LIMB_W * WORDS;
    localparam int IDX_W = idx_width(WORDS);

    state_e             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   idx_d;
    logic               carry_q;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;      // already inverted for subtract
    logic [W-1:0]       sum_q;
    logic [W-1:0]       sum_d;
    logic               cout_q;
    logic               ovf_q;
    logic               done_q;

    logic [LIMB_W-1:0]  a_limb;
    logic [LIMB_W-1:0]  b_limb;
    logic [LIMB_W-1:0]  add_sum;
    logic               add_cout;
    logic               last_limb;
    logic               ovf_d;

    // Select the current limb of each operand and merge the adder result into the sum image.
    always_comb begin
        a_limb = '0;
        b_limb = '0;
        sum_d  = sum_q;
        for (int i = 0; i < WORDS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_limb                  = a_q[i*LIMB_W +: LIMB_W];
                b_limb                  = b_q[i*LIMB_W +: LIMB_W];
                sum_d[i*LIMB_W +: LIMB_W] = add_sum;
            end
        end
    end

    assign idx_d     = idx_q + 1'b1;
    assign last_limb = (idx_q == IDX_W'(WORDS - 1));

    // Signed overflow: operands agree in sign but the top-limb result does not.
    assign ovf_d = (a_q[W-1] == b_q[W-1]) && (add_sum[LIMB_W-1] != a_q[W-1]);

    adder_32_bit u_adder (
        .a    (a_limb),
        .b    (b_limb),
        .cin  (carry_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Control FSM and all datapath registers; reset overrides any start in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        a_q     <= a_in;
                        b_q     <= op_sub ? ~b_in : b_in;
                        carry_q <= op_sub ? 1'b1 : cin;
                        idx_q   <= '0;
                        sum_q   <= '0;
                        cout_q  <= 1'b0;
                        ovf_q   <= 1'b0;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sum_q   <= sum_d;
                    carry_q <= add_cout;
                    idx_q   <= idx_d;
                    if (last_limb) begin
                        // Index is parked at zero so a non-power-of-two WORDS never leaves it out of range.
                        idx_q   <= '0;
                        cout_q  <= add_cout;
                        ovf_q   <= ovf_d;
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy     = (state_q == ST_RUN);
    assign done     = done_q;
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_wide_adder_seq.sv
// Directed bench for wide_adder_seq: a 4-limb instance for the bulk of the cases and a 1-limb one for latency.
module tb_wide_adder_seq;

    localparam int W  = 128;
    localparam int W1 = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, op_sub, cin;
    logic [W-1:0]  a_in, b_in, sum;
    logic          busy, done, cout, overflow;

    logic          start1, op_sub1, cin1;
    logic [W1-1:0] a1, b1, sum1;
    logic          busy1, done1, cout1, ovf1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wide_adder_seq #(.WORDS(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .op_sub(op_sub), .cin(cin),
        .a_in(a_in), .b_in(b_in), .busy(busy), .done(done), .sum(sum),
        .cout(cout), .overflow(overflow)
    );

    wide_adder_seq #(.WORDS(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .op_sub(op_sub1), .cin(cin1),
        .a_in(a1), .b_in(b1), .busy(busy1), .done(done1), .sum(sum1),
        .cout(cout1), .overflow(ovf1)
    );

    // Present one start for one cycle; returns at the negedge after the accepting edge.
    task automatic launch(input logic sub, input logic c, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start = 1'b1; op_sub = sub; cin = c; a_in = a; b_in = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Count cycles (edges after the accept edge) until done is seen; bounded.
    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if ({busy, done, cout, overflow} !== 4'b0) begin n_err++; $display("FAIL reset.flags got %b want 0000", {busy, done, cout, overflow}); end
        n_cmp++; if (sum !== '0) begin n_err++; $display("FAIL reset.sum got %h want 0", sum); end
        n_cmp++; if ({busy1, done1, cout1, ovf1, |sum1} !== 5'b0) begin n_err++; $display("FAIL reset.dut1 got %b want 00000", {busy1, done1, cout1, ovf1, |sum1}); end
        rst = 1'b0;
    endtask

    task automatic test_add_basic;
        int n;
        launch(1'b0, 1'b0, 128'd5, 128'd9);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL add_basic.busy got %b want 1", busy); end
        wait_done(n);
        n_cmp++; if (n !== 4) begin n_err++; $display("FAIL add_basic.latency got %0d want 4", n); end
        n_cmp++; if (sum !== 128'd14) begin n_err++; $display("FAIL add_basic.sum got %h want %h", sum, 128'd14); end
        n_cmp++; if ({cout, overflow, busy} !== 3'b000) begin n_err++; $display("FAIL add_basic.flags got %b want 000", {cout, overflow, busy}); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0 || sum !== 128'd14) begin n_err++; $display("FAIL add_basic.hold got done=%b sum=%h want done=0 sum=e", done, sum); end
    endtask

    task automatic test_carry_chain;
        int n;
        launch(1'b0, 1'b0, 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF, 128'd1);
        wait_done(n);
        n_cmp++; if (sum !== 128'h0000_0000_0000_0000_0000_0001_0000_0000) begin n_err++; $display("FAIL carry_chain.sum got %h want 1_0000_0000", sum); end
        n_cmp++; if ({cout, overflow} !== 2'b00) begin n_err++; $display("FAIL carry_chain.flags got %b want 00", {cout, overflow}); end
    endtask

    task automatic test_add_cin;
        int n;
        launch(1'b0, 1'b1, {W{1'b1}}, 128'd0);
        wait_done(n);
        n_cmp++; if (sum !== '0) begin n_err++; $display("FAIL add_cin.sum got %h want 0", sum); end
        n_cmp++; if ({cout, overflow} !== 2'b10) begin n_err++; $display("FAIL add_cin.flags got %b want 10", {cout, overflow}); end
    endtask

    task automatic test_subtract;
        int n;
        // cin=0 for the first case proves the subtract forces its own +1.
        launch(1'b1, 1'b0, 128'd128, 128'd64);
        wait_done(n);
        n_cmp++; if (sum !== 128'd64) begin n_err++; $display("FAIL sub_128_64.sum got %h want 40", sum); end
        n_cmp++; if ({cout, overflow} !== 2'b10) begin n_err++; $display("FAIL sub_128_64.flags got %b want 10", {cout, overflow}); end
        launch(1'b1, 1'b1, 128'd0, 128'd1);
        wait_done(n);
        n_cmp++; if (sum !== {W{1'b1}}) begin n_err++; $display("FAIL sub_0_1.sum got %h want all-ones", sum); end
        n_cmp++; if ({cout, overflow} !== 2'b00) begin n_err++; $display("FAIL sub_0_1.flags got %b want 00", {cout, overflow}); end
    endtask

    task automatic test_overflow;
        int n;
        launch(1'b0, 1'b0, {1'b0, {(W-1){1'b1}}}, 128'd1);
        wait_done(n);
        n_cmp++; if (sum !== {1'b1, {(W-1){1'b0}}}) begin n_err++; $display("FAIL overflow.sum got %h want 8000..0", sum); end
        n_cmp++; if ({cout, overflow} !== 2'b01) begin n_err++; $display("FAIL overflow.flags got %b want 01", {cout, overflow}); end
    endtask

    task automatic test_start_mid_run;
        int n;
        int extra_done;
        launch(1'b0, 1'b0, 128'd5, 128'd9);
        @(negedge clk);
        start = 1'b1; op_sub = 1'b1; a_in = 128'd100; b_in = 128'd200;
        @(negedge clk);
        start = 1'b0;
        n = 2;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_cmp++; if (n !== 4) begin n_err++; $display("FAIL mid_start.latency got %0d want 4", n); end
        n_cmp++; if (sum !== 128'd14) begin n_err++; $display("FAIL mid_start.sum got %h want e", sum); end
        extra_done = 0;
        repeat (6) begin
            @(negedge clk);
            if (done || busy) extra_done++;
        end
        n_cmp++; if (extra_done !== 0) begin n_err++; $display("FAIL mid_start.queued got %0d active cycles want 0", extra_done); end
    endtask

    task automatic test_back_to_back;
        int n;
        launch(1'b0, 1'b0, 128'd1, 128'd2);
        wait_done(n);
        n_cmp++; if (sum !== 128'd3) begin n_err++; $display("FAIL b2b.first_sum got %h want 3", sum); end
        // Issue the next start in the done cycle itself.
        start = 1'b1; op_sub = 1'b0; cin = 1'b0; a_in = 128'd10; b_in = 128'd20;
        @(negedge clk);
        start = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b.accept got busy=%b want 1", busy); end
        wait_done(n);
        n_cmp++; if (n !== 4) begin n_err++; $display("FAIL b2b.latency got %0d want 4", n); end
        n_cmp++; if (sum !== 128'd30) begin n_err++; $display("FAIL b2b.second_sum got %h want 1e", sum); end
    endtask

    task automatic test_rst_mid_run;
        int active;
        launch(1'b0, 1'b0, 128'd5, 128'd9);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if ({busy, done, cout, overflow} !== 4'b0 || sum !== '0) begin n_err++; $display("FAIL rst_mid.outputs got flags=%b sum=%h want 0", {busy, done, cout, overflow}, sum); end
        active = 0;
        repeat (6) begin
            @(negedge clk);
            if (done || busy) active++;
        end
        n_cmp++; if (active !== 0) begin n_err++; $display("FAIL rst_mid.no_done got %0d active cycles want 0", active); end
    endtask

    task automatic test_rst_wins;
        @(negedge clk);
        rst = 1'b1; start = 1'b1; a_in = 128'd7; b_in = 128'd7;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_wins.busy got %b want 0", busy); end
    endtask

    task automatic test_words1;
        int n;
        @(negedge clk);
        start1 = 1'b1; op_sub1 = 1'b0; cin1 = 1'b0; a1 = 32'd5; b1 = 32'd9;
        @(negedge clk);
        start1 = 1'b0;
        n = 0;
        while (!done1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_cmp++; if (n !== 1) begin n_err++; $display("FAIL words1.latency got %0d want 1", n); end
        n_cmp++; if (sum1 !== 32'd14 || cout1 !== 1'b0 || ovf1 !== 1'b0) begin n_err++; $display("FAIL words1.result got sum=%h cout=%b ovf=%b want e/0/0", sum1, cout1, ovf1); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op_sub = 1'b0; cin = 1'b0; a_in = '0; b_in = '0;
        start1 = 1'b0; op_sub1 = 1'b0; cin1 = 1'b0; a1 = '0; b1 = '0;
        test_reset();
        test_add_basic();
        test_carry_chain();
        test_add_cin();
        test_subtract();
        test_overflow();
        test_start_mid_run();
        test_back_to_back();
        test_rst_mid_run();
        test_rst_wins();
        test_words1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
